// File: rtl/sd_cmd_sequencer_if.sv
// Byte-level SPI master control bus driven by the SD command sequencer.
interface sd_cmd_sequencer_if;
  logic [7:0] spi_data_in;
  logic       spi_w_data;
  logic       spi_w_conf;
  logic       spi_ss_in;
  logic       spi_busy;
  logic [7:0] spi_data_out;

  modport master (
    output spi_data_in, spi_w_data, spi_w_conf, spi_ss_in,
    input  spi_busy, spi_data_out
  );

  modport slave (
    input  spi_data_in, spi_w_data, spi_w_conf, spi_ss_in,
    output spi_busy, spi_data_out
  );
endinterface

// File: rtl/sd_cmd_sequencer.sv
// SD command sequencer: optional SPI clock config, card wake-up, 6-byte frame,
// then 0xFF polling until an R1 byte (MSB clear) or the poll limit.
module sd_cmd_sequencer #(
  parameter int unsigned MAX_POLL     = 8,
  parameter int unsigned DUMMY_CYCLES = 2048,
  parameter int unsigned BUSY_TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [5:0]  cmd_index,
  input  logic [31:0] cmd_arg,
  input  logic [6:0]  cmd_crc,
  input  logic [7:0]  clk_div,
  input  logic        do_conf,
  input  logic        do_dummy,
  input  logic        hold_cs,
  output logic        ready,
  output logic        done,
  output logic [7:0]  resp,
  output logic        timeout,
  output logic        bus_err,
  sd_cmd_sequencer_if.master spi
);

  localparam int unsigned DW = $clog2(DUMMY_CYCLES + 1);
  localparam int unsigned WW = $clog2(BUSY_TIMEOUT + 1);
  localparam int unsigned PW = $clog2(MAX_POLL + 1);
  localparam logic [DW-1:0] DUMMY_LAST = DW'(DUMMY_CYCLES - 1);
  localparam logic [WW-1:0] WD_LAST    = WW'(BUSY_TIMEOUT - 1);
  localparam logic [PW-1:0] POLL_LAST  = PW'(MAX_POLL - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CONF, S_DUMMY, S_SEND, S_WAIT_HI, S_WAIT_LO, S_NEXT, S_FINISH
  } state_t;

  state_t        state;
  logic [5:0]    idx_q;
  logic [31:0]   arg_q;
  logic [6:0]    crc_q;
  logic          dummy_q;
  logic          hold_q;
  logic [2:0]    byte_idx;
  logic          polling;
  logic [PW-1:0] poll_cnt;
  logic [DW-1:0] dummy_cnt;
  logic [WW-1:0] wd_cnt;
  logic [7:0]    rx;
  logic [7:0]    next_frame;

  // Frame byte that follows the one at byte_idx (B1..B5)
  always_comb begin
    next_frame = {crc_q, 1'b1};
    case (byte_idx)
      3'd0:    next_frame = arg_q[31:24];
      3'd1:    next_frame = arg_q[23:16];
      3'd2:    next_frame = arg_q[15:8];
      3'd3:    next_frame = arg_q[7:0];
      default: next_frame = {crc_q, 1'b1};
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state           <= S_IDLE;
      ready           <= 1'b1;
      done            <= 1'b0;
      resp            <= 8'hFF;
      timeout         <= 1'b0;
      bus_err         <= 1'b0;
      spi.spi_w_data  <= 1'b0;
      spi.spi_w_conf  <= 1'b0;
      spi.spi_ss_in   <= 1'b1;
      spi.spi_data_in <= '0;
      idx_q           <= '0;
      arg_q           <= '0;
      crc_q           <= '0;
      dummy_q         <= 1'b0;
      hold_q          <= 1'b0;
      byte_idx        <= '0;
      polling         <= 1'b0;
      poll_cnt        <= '0;
      dummy_cnt       <= '0;
      wd_cnt          <= '0;
      rx              <= '0;
    end else begin
      spi.spi_w_data <= 1'b0;
      spi.spi_w_conf <= 1'b0;
      done           <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            idx_q    <= cmd_index;
            arg_q    <= cmd_arg;
            crc_q    <= cmd_crc;
            dummy_q  <= do_dummy;
            hold_q   <= hold_cs;
            timeout  <= 1'b0;
            bus_err  <= 1'b0;
            ready    <= 1'b0;
            byte_idx <= '0;
            polling  <= 1'b0;
            if (do_conf) begin
              state           <= S_CONF;
              spi.spi_w_conf  <= 1'b1;
              spi.spi_data_in <= clk_div;
              spi.spi_ss_in   <= 1'b1;
            end else if (do_dummy) begin
              state         <= S_DUMMY;
              dummy_cnt     <= '0;
              spi.spi_ss_in <= 1'b1;
            end else begin
              state           <= S_SEND;
              spi.spi_data_in <= {2'b01, cmd_index};
              spi.spi_w_data  <= 1'b1;
              spi.spi_ss_in   <= 1'b0;
            end
          end
        end
        S_CONF: begin
          if (dummy_q) begin
            state     <= S_DUMMY;
            dummy_cnt <= '0;
          end else begin
            state           <= S_SEND;
            spi.spi_data_in <= {2'b01, idx_q};
            spi.spi_w_data  <= 1'b1;
            spi.spi_ss_in   <= 1'b0;
          end
        end
        S_DUMMY: begin
          if (dummy_cnt == DUMMY_LAST) begin
            state           <= S_SEND;
            spi.spi_data_in <= {2'b01, idx_q};
            spi.spi_w_data  <= 1'b1;
            spi.spi_ss_in   <= 1'b0;
          end else begin
            dummy_cnt <= dummy_cnt + 1'b1;
          end
        end
        S_SEND: begin
          state  <= S_WAIT_HI;
          wd_cnt <= '0;
        end
        S_WAIT_HI: begin
          if (spi.spi_busy) begin
            state  <= S_WAIT_LO;
            wd_cnt <= '0;
          end else if (wd_cnt == WD_LAST) begin
            bus_err       <= 1'b1;
            resp          <= 8'hFF;
            done          <= 1'b1;
            spi.spi_ss_in <= ~hold_q;
            state         <= S_FINISH;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        S_WAIT_LO: begin
          if (!spi.spi_busy) begin
            rx    <= spi.spi_data_out;
            state <= S_NEXT;
          end else if (wd_cnt == WD_LAST) begin
            bus_err       <= 1'b1;
            resp          <= 8'hFF;
            done          <= 1'b1;
            spi.spi_ss_in <= ~hold_q;
            state         <= S_FINISH;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        S_NEXT: begin
          // Frame-phase receive bytes are never inspected; only poll bytes are.
          if (!polling) begin
            state          <= S_SEND;
            spi.spi_w_data <= 1'b1;
            if (byte_idx != 3'd5) begin
              byte_idx        <= byte_idx + 1'b1;
              spi.spi_data_in <= next_frame;
            end else begin
              polling         <= 1'b1;
              poll_cnt        <= '0;
              spi.spi_data_in <= 8'hFF;
            end
          end else if (!rx[7]) begin
            resp          <= rx;
            done          <= 1'b1;
            spi.spi_ss_in <= ~hold_q;
            state         <= S_FINISH;
          end else if (poll_cnt == POLL_LAST) begin
            timeout       <= 1'b1;
            resp          <= 8'hFF;
            done          <= 1'b1;
            spi.spi_ss_in <= ~hold_q;
            state         <= S_FINISH;
          end else begin
            poll_cnt        <= poll_cnt + 1'b1;
            spi.spi_data_in <= 8'hFF;
            spi.spi_w_data  <= 1'b1;
            state           <= S_SEND;
          end
        end
        S_FINISH: begin
          ready <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_cmd_sequencer.sv
// Directed bench for sd_cmd_sequencer with a small SPI slave model.
module tb_sd_cmd_sequencer;
  logic        clk;
  logic        rst;
  logic        start;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_arg;
  logic [6:0]  cmd_crc;
  logic [7:0]  clk_div;
  logic        do_conf;
  logic        do_dummy;
  logic        hold_cs;
  logic        ready;
  logic        done;
  logic [7:0]  resp;
  logic        timeout;
  logic        bus_err;

  sd_cmd_sequencer_if spi_bus ();

  sd_cmd_sequencer #(.MAX_POLL(8), .DUMMY_CYCLES(2048), .BUSY_TIMEOUT(1024)) dut (
    .clk(clk), .rst(rst), .start(start), .cmd_index(cmd_index), .cmd_arg(cmd_arg),
    .cmd_crc(cmd_crc), .clk_div(clk_div), .do_conf(do_conf), .do_dummy(do_dummy),
    .hold_cs(hold_cs), .ready(ready), .done(done), .resp(resp), .timeout(timeout),
    .bus_err(bus_err), .spi(spi_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic       slave_en;
  logic       clr_log;
  logic [7:0] poll_resp [0:3];
  int         poll_len;
  logic [7:0] wlog [0:63];
  int         nbytes, cbytes, conf_cnt, done_cnt, bcnt, ss_run, ss_max;
  logic [7:0] conf_data;

  // SPI slave: busy for 3 cycles after each byte; 0x00 during the frame, then scripted poll bytes.
  always @(posedge clk) begin
    if (clr_log) begin
      nbytes <= 0; cbytes <= 0; conf_cnt <= 0; done_cnt <= 0; bcnt <= 0;
      ss_run <= 0; ss_max <= 0; conf_data <= 8'h00;
      spi_bus.spi_busy <= 1'b0; spi_bus.spi_data_out <= 8'h00;
    end else begin
      if (spi_bus.spi_ss_in) ss_run <= ss_run + 1; else ss_run <= 0;
      if (ss_run > ss_max) ss_max <= ss_run;
      if (spi_bus.spi_w_conf) begin conf_cnt <= conf_cnt + 1; conf_data <= spi_bus.spi_data_in; end
      if (done) begin done_cnt <= done_cnt + 1; cbytes <= 0; end
      if (slave_en && spi_bus.spi_w_data) begin
        if (nbytes < 64) wlog[nbytes] <= spi_bus.spi_data_in;
        nbytes <= nbytes + 1;
        cbytes <= cbytes + 1;
        if (cbytes < 6) spi_bus.spi_data_out <= 8'h00;
        else if (cbytes - 6 < poll_len) spi_bus.spi_data_out <= poll_resp[cbytes-6];
        else spi_bus.spi_data_out <= 8'hFF;
        spi_bus.spi_busy <= 1'b1;
        bcnt <= 3;
      end else if (bcnt != 0) begin
        bcnt <= bcnt - 1;
        if (bcnt == 1) spi_bus.spi_busy <= 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_bytes(input string tag, input int n, input logic [127:0] e);
    logic [7:0] eb;
    check({tag, "_count"}, nbytes, n);
    for (int i = 0; i < n; i++) begin
      eb = e[8*(n-1-i) +: 8];
      check($sformatf("%s_b%0d", tag, i), wlog[i], eb);
    end
  endtask

  task automatic clear_log();
    clr_log = 1'b1;
    @(negedge clk);
    clr_log = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int cyc);
    logic seen;
    seen = 1'b0;
    cyc = 0;
    while (cyc < limit && !seen) begin
      @(negedge clk);
      cyc++;
      if (done) seen = 1'b1;
    end
    check("done_seen", seen, 1'b1);
  endtask

  task automatic wait_wdata(input int count, input int limit);
    int n;
    int cyc;
    n = 0;
    cyc = 0;
    while (cyc < limit && n < count) begin
      @(negedge clk);
      cyc++;
      if (spi_bus.spi_w_data) n++;
    end
    check("wdata_seen", n, count);
  endtask

  initial begin
    int cyc;
    rst = 1'b0; start = 1'b0; cmd_index = '0; cmd_arg = '0; cmd_crc = '0; clk_div = '0;
    do_conf = 1'b0; do_dummy = 1'b0; hold_cs = 1'b0;
    slave_en = 1'b1; clr_log = 1'b1; poll_len = 0;
    for (int i = 0; i < 4; i++) poll_resp[i] = 8'hFF;
    repeat (3) @(negedge clk);
    check("rst_ready", ready, 1'b1);
    check("rst_done", done, 1'b0);
    check("rst_resp", resp, 8'hFF);
    check("rst_timeout", timeout, 1'b0);
    check("rst_bus_err", bus_err, 1'b0);
    check("rst_ss", spi_bus.spi_ss_in, 1'b1);
    check("rst_wdata", spi_bus.spi_w_data, 1'b0);
    check("rst_wconf", spi_bus.spi_w_conf, 1'b0);
    check("rst_data_in", spi_bus.spi_data_in, 8'h00);
    rst = 1'b1;
    clr_log = 1'b0;
    @(negedge clk);

    // CMD0 with config and wake-up
    cmd_index = 6'd0; cmd_arg = 32'h0; cmd_crc = 7'h4A; clk_div = 8'd5;
    do_conf = 1'b1; do_dummy = 1'b1; hold_cs = 1'b0;
    poll_resp[0] = 8'hFF; poll_resp[1] = 8'h01; poll_len = 2;
    clear_log();
    pulse_start();
    check("t1_ready_low", ready, 1'b0);
    wait_done(5000, cyc);
    check("t1_resp", resp, 8'h01);
    check("t1_timeout", timeout, 1'b0);
    check("t1_bus_err", bus_err, 1'b0);
    check("t1_ss_done", spi_bus.spi_ss_in, 1'b1);
    @(negedge clk);
    check("t1_done_pulse", done, 1'b0);
    check("t1_ready", ready, 1'b1);
    repeat (2) @(negedge clk);
    check("t1_done_cnt", done_cnt, 1);
    check("t1_conf_cnt", conf_cnt, 1);
    check("t1_conf_data", conf_data, 8'd5);
    check("t1_ss_run_min", (ss_max >= 2048), 1'b1);
    check("t1_ss_run_max", (ss_max <= 2060), 1'b1);
    check_bytes("t1", 8, 128'h40_00000000_95_FF_FF);

    // CMD17 holding CS
    cmd_index = 6'd17; cmd_arg = 32'h12345678; cmd_crc = 7'h2A;
    do_conf = 1'b0; do_dummy = 1'b0; hold_cs = 1'b1;
    poll_resp[0] = 8'h00; poll_len = 1;
    clear_log();
    pulse_start();
    wait_done(2000, cyc);
    check("t2_resp", resp, 8'h00);
    check("t2_timeout", timeout, 1'b0);
    check("t2_ss_done", spi_bus.spi_ss_in, 1'b0);
    repeat (5) @(negedge clk);
    check("t2_ss_held", spi_bus.spi_ss_in, 1'b0);
    check("t2_ready", ready, 1'b1);
    check_bytes("t2", 7, 128'h51_12345678_55_FF);

    // Poll timeout: slave never answers
    cmd_index = 6'd55; cmd_arg = 32'h0; cmd_crc = 7'h32; hold_cs = 1'b0;
    poll_len = 0;
    clear_log();
    pulse_start();
    wait_done(3000, cyc);
    check("t3_timeout", timeout, 1'b1);
    check("t3_resp", resp, 8'hFF);
    check("t3_bus_err", bus_err, 1'b0);
    repeat (5) @(negedge clk);
    check("t3_done_cnt", done_cnt, 1);
    check("t3_ss", spi_bus.spi_ss_in, 1'b1);
    check_bytes("t3", 14, 128'h77_00000000_65_FFFFFFFFFFFFFFFF);

    // Busy never rises: watchdog
    slave_en = 1'b0;
    clear_log();
    pulse_start();
    wait_done(2000, cyc);
    check("t4_cycles", cyc, 1025);
    check("t4_bus_err", bus_err, 1'b1);
    check("t4_resp", resp, 8'hFF);
    check("t4_timeout", timeout, 1'b0);
    check("t4_ss", spi_bus.spi_ss_in, 1'b1);
    slave_en = 1'b1;
    @(negedge clk);
    check("t4_ready", ready, 1'b1);

    // Reset during the third frame byte, then a clean CMD8
    cmd_index = 6'd8; cmd_arg = 32'h000001AA; cmd_crc = 7'h43;
    poll_resp[0] = 8'h01; poll_len = 1;
    clear_log();
    pulse_start();
    check("t5_first_wdata", spi_bus.spi_w_data, 1'b1);
    wait_wdata(2, 200);
    check("t5_third_byte", spi_bus.spi_data_in, 8'h00);
    rst = 1'b0;
    @(negedge clk);
    check("t5_rst_ss", spi_bus.spi_ss_in, 1'b1);
    check("t5_rst_ready", ready, 1'b1);
    check("t5_rst_wdata", spi_bus.spi_w_data, 1'b0);
    rst = 1'b1;
    repeat (6) @(negedge clk);
    clear_log();
    pulse_start();
    wait_done(2000, cyc);
    check("t5_resp", resp, 8'h01);
    check_bytes("t5", 7, 128'h48_000001AA_87_FF);

    // start held high: one command per ready window, latched arg immune to changes
    cmd_index = 6'd17; cmd_arg = 32'hCAFEF00D; cmd_crc = 7'h00;
    clear_log();
    start = 1'b1;
    wait_wdata(1, 50);
    cmd_arg = 32'h0BADBEEF;
    wait_done(2000, cyc);
    check("t6_resp1", resp, 8'h01);
    wait_wdata(1, 50);
    start = 1'b0;
    wait_done(2000, cyc);
    repeat (20) @(negedge clk);
    check("t6_done_cnt", done_cnt, 2);
    check("t6_ready", ready, 1'b1);
    check_bytes("t6", 14, 128'h51_CAFEF00D_01_FF_51_0BADBEEF_01_FF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "bench time limit");
  end
endmodule
